// File: rtl/inst_loader.sv
// Boot loader: assembles a length-prefixed little-endian byte stream into instruction words,
// writes them 1 cycle after each word's last byte, holds the core in reset until the image is in.
module inst_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  output logic                  inst_we_o,
  output logic [ADDR_WIDTH-1:0] inst_waddr_o,
  output logic [31:0]           inst_wdata_o,
  output logic                  core_rst_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [31:0]           checksum_o
);

  typedef enum logic [1:0] {S_LEN, S_DATA, S_FLUSH, S_DONE} state_t;

  localparam logic [32:0] DEPTH = 33'd1 << ADDR_WIDTH;

  state_t      state, state_nxt;
  logic [1:0]  byte_cnt;
  logic [31:0] word_cnt;
  logic [31:0] len_q;
  logic [31:0] shift_q;
  logic [31:0] word_asm;
  logic        xfer;
  logic        last_byte;
  logic        last_word;
  logic        fits;

  // Bytes enter at the top so the first byte of a word ends up in bits 7:0.
  assign word_asm  = {byte_data_i, shift_q[31:8]};
  assign xfer      = byte_valid_i && byte_ready_o;
  assign last_byte = xfer && (byte_cnt == 2'd3);
  assign last_word = (word_cnt + 32'd1) == len_q;
  assign fits      = {1'b0, word_cnt} < DEPTH;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_LEN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start_i) begin
      state_nxt = S_LEN;
    end else begin
      case (state)
        S_LEN:   if (last_byte) state_nxt = (word_asm == 32'd0) ? S_DONE : S_DATA;
        S_DATA:  if (last_byte && last_word) state_nxt = S_FLUSH;
        S_FLUSH: state_nxt = S_DONE;
        default: state_nxt = S_DONE;
      endcase
    end
  end

  always_comb begin
    byte_ready_o = (state == S_LEN) || (state == S_DATA);
    core_rst_o   = (state != S_DONE);
    done_o       = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt     <= 2'd0;
      word_cnt     <= 32'd0;
      len_q        <= 32'd0;
      shift_q      <= 32'd0;
      inst_we_o    <= 1'b0;
      inst_waddr_o <= '0;
      inst_wdata_o <= 32'd0;
      err_o        <= 1'b0;
      checksum_o   <= 32'd0;
    end else begin
      inst_we_o <= 1'b0;
      if (start_i) begin
        byte_cnt   <= 2'd0;
        word_cnt   <= 32'd0;
        err_o      <= 1'b0;
        checksum_o <= 32'd0;
      end else if (xfer) begin
        byte_cnt <= byte_cnt + 2'd1;
        shift_q  <= word_asm;
        if (last_byte && state == S_LEN) begin
          len_q    <= word_asm;
          word_cnt <= 32'd0;
        end
        if (last_byte && state == S_DATA) begin
          inst_wdata_o <= word_asm;
          inst_waddr_o <= word_cnt[ADDR_WIDTH-1:0];
          // Words past the end of memory are still checksummed but never written.
          inst_we_o    <= fits;
          if (!fits) err_o <= 1'b1;
          checksum_o   <= checksum_o ^ word_asm;
          word_cnt     <= word_cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Boot-time program loader upstream of the instruction memory and core.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into the instruction memory write port and holds the core in reset until the image is complete.
- Replaces preloaded instruction images, so the same SoC runs any program streamed in from a host or testbench.

Parameters:
ADDR_WIDTH, 10, word-address width of instruction memory; capacity DEPTH = 2**ADDR_WIDTH words (1024 words).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous reset, active-low (rst=0 resets immediately, independent of clk).
start_i  in  1  synchronous restart pulse; valid in any state.
byte_valid_i  in  1  byte_data_i is valid this cycle.
byte_data_i  in  8  stream byte.
byte_ready_o  out  1  loader accepts a byte this cycle.
inst_we_o  out  1  one-cycle instruction memory write strobe.
inst_waddr_o  out  ADDR_WIDTH  word address of the write.
inst_wdata_o  out  32  instruction word written.
core_rst_o  out  1  active-high reset to core; 1 while loading.
done_o  out  1  image fully loaded, core released.
err_o  out  1  sticky: image longer than DEPTH.
checksum_o  out  32  XOR of all received data words.

Behaviour:
- Stream format: 4-byte length N (little-endian word count), then N words of 4 bytes each, little-endian (first byte = bits 7:0).
- Transfer rule: a byte is transferred on a rising edge where byte_valid_i=1 and byte_ready_o=1. byte_ready_o is combinational from state only, never from byte_valid_i.
- Reset (rst=0):
  - state=S_LEN; byte counter=0; word counter=0.
  - byte_ready_o=1, inst_we_o=0, inst_waddr_o=0, inst_wdata_o=0.
  - core_rst_o=1, done_o=0, err_o=0, checksum_o=0.
  - Reset mid-load discards all progress. Memory contents already written stay as they are.
- States:
  - S_LEN: ready=1. Shift bytes into the length register. On the 4th transfer, go to S_DONE if N==0, else S_DATA. The word counter is cleared.
  - S_DATA: ready=1. Shift bytes into the assembly register. On the 4th transfer, on that same edge:
    - inst_wdata_o <= assembled word; inst_waddr_o <= word counter[ADDR_WIDTH-1:0].
    - inst_we_o <= 1 only if word counter < DEPTH. Otherwise inst_we_o stays 0 and err_o <= 1.
    - checksum_o ^= word; word counter++.
    - If this was word N, go to S_FLUSH.
  - S_FLUSH: ready=0. One cycle only; it exists so the final write strobe completes before the core is released. Then go to S_DONE.
  - S_DONE: ready=0, core_rst_o=0, done_o=1. Held until start_i or rst.
- inst_we_o is registered: high exactly one cycle after the edge that transferred the 4th byte, and low otherwise.
- Latency:
  - Write strobe: 1 cycle after the last byte of a word.
  - core_rst_o falls 2 edges after the final byte transfer (the edge that drives the last inst_we_o, then the S_FLUSH edge).
  - For N=0, core_rst_o falls on the edge after the 4th length byte.
- Back-pressure: byte_valid_i may drop mid-word. Partial bytes are held indefinitely and no timeout applies. Bytes offered while ready=0 are ignored.
- Word counter is 32 bits wide and does not wrap. Words beyond DEPTH are consumed, not written, and set err_o; loading still completes normally.
- start_i=1 on an edge, in any state, overrides a simultaneous byte transfer. It does the following:
  - state=S_LEN; counters and checksum cleared; err_o cleared.
  - core_rst_o=1; done_o=0; inst_we_o=0.
- Checksum covers all N words, including words dropped because of overflow.

Test Plan:
- Basic load: N=2, bytes 13 00 00 00 | 93 00 10 00 -> inst_we_o at addr 0 with 0x00000013, then at addr 1 with 0x00100093. checksum_o=0x00100080; core_rst_o falls 2 edges after the last byte; done_o=1.
- Zero length: bytes 00 00 00 00 -> no inst_we_o pulse; done_o=1 and core_rst_o=0 after one edge; byte_ready_o=0.
- Back-pressure: N=1, valid toggled 1/0 every cycle with word 0xDEADBEEF (EF BE AD DE) -> exactly one write, 0xDEADBEEF at addr 0, issued only after the 4th accepted byte.
- Overflow with ADDR_WIDTH=2: N=5, five words -> writes to addrs 0..3 only; err_o=1 after the 5th word; done_o=1; checksum includes all 5 words.
- Restart: start_i pulsed after 2 data bytes of word 0 -> core_rst_o=1, err_o=0, checksum_o=0; a fresh N=1 stream loads correctly to addr 0.
- Async reset: rst driven low between clock edges during S_DATA -> all outputs immediately take their reset values; a new stream after rst=1 loads correctly.
